// File: rtl/mips_pkg.sv
// Shared definitions for the Mini-MIPS multi-cycle controller.
// Contents: opcode constants, sequencer state encoding, and opcode
// classification helpers (branch / immediate-operand / legal).
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ADDIU = 6'd9;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ANDI  = 6'd12;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_XORI  = 6'd14;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_LBU   = 6'd36;
   localparam logic [5:0] OP_BEQ   = 6'd41;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BR_LO = 6'd48;
   localparam logic [5:0] OP_BR_HI = 6'd54;
   localparam logic [5:0] OP_HALT  = 6'd63;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      HALT   = 3'd6,
      ERR    = 3'd7
   } state_t;

   function automatic logic is_branch(input logic [5:0] op);
      return (op == OP_BEQ) || ((op >= OP_BR_LO) && (op <= OP_BR_HI));
   endfunction

   // Opcodes whose second ALU operand is the sign-extended immediate.
   function automatic logic is_imm(input logic [5:0] op);
      case (op)
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LW, OP_LBU, OP_SW: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_J) || (op == OP_HALT) ||
             is_imm(op) || is_branch(op);
   endfunction

endpackage

// File: rtl/mips_ctrl_timeout.sv
// Memory-wait watchdog shared by the FETCH and MEM states.
// Ports:
//   clk, rst  : clock, async active-high reset
//   clr       : zero the counter (outside a wait, or on ack)
//   en        : count one waited cycle
//   expired   : current cycle is the LIMIT-th without ack
module mips_ctrl_timeout #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Counter holds the number of cycles already spent waiting before the
   // current one; it saturates once expired so it never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  cnt <= '0;
      else if (clr)             cnt <= '0;
      else if (en && !expired)  cnt <= cnt + CW'(1);
   end

   assign expired = (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle sequencer for the Mini-MIPS core. Owns pc and ir, steps each
// instruction through FETCH/DECODE/EXEC/MEM/WB, drives ALU selects,
// register-file write controls and the instruction/data memory handshakes.
// Optional macro CTRL_PERF_CNT_EN adds the instr_retired counter output.
// Ports:
//   clk, rst                  : clock, async active-high reset
//   start                     : pulse, leaves IDLE/HALT into FETCH
//   imem_req/ack/rdata/addr   : instruction fetch handshake (addr = pc)
//   dmem_req/we/ack           : data access handshake (we=1 store)
//   alu_zero                  : branch condition from datapath
//   alu_op_code/func/src_imm  : ALU selects, valid in EXEC
//   ir, pc                    : instruction register, program counter
//   reg_we/reg_dst_rd/wb_sel_mem : write-back controls, valid in WB
//   busy, halted, err         : status
//   instr_retired             : (CTRL_PERF_CNT_EN only) retired count
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter int          PC_W        = 10,
   parameter int unsigned RESET_PC    = 0,
   parameter int          MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [PC_W-1:0] imem_addr,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic            alu_zero,
   output logic [5:0]      alu_op_code,
   output logic [5:0]      alu_func,
   output logic            alu_src_imm,
   output logic [31:0]     ir,
   output logic [PC_W-1:0] pc,
   output logic            reg_we,
   output logic            reg_dst_rd,
   output logic            wb_sel_mem,
   output logic            busy,
   output logic            halted,
   output logic            err
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [31:0]     instr_retired
`endif
);

   state_t          state, state_n;
   logic [PC_W-1:0] pc_n;
   logic [31:0]     ir_n;
   logic [5:0]      op;
   logic [PC_W-1:0] br_off;
   logic            waiting, wait_ack, to_expired;
   logic            retire;

   assign op     = ir[31:26];
   // Signed cast sign-extends (or truncates) the 16-bit offset to PC_W.
   assign br_off = PC_W'($signed(ir[15:0]));

   // Timeout window restarts on every entry to FETCH/MEM: the counter is
   // held clear outside those states and cleared again on the ack cycle,
   // which covers the direct MEM(store) -> FETCH path.
   assign waiting  = (state == FETCH) || (state == MEM);
   assign wait_ack = ((state == FETCH) && imem_ack) || ((state == MEM) && dmem_ack);

   mips_ctrl_timeout #(.LIMIT(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (!waiting || wait_ack),
      .en      (waiting),
      .expired (to_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         pc    <= PC_W'(RESET_PC);
         ir    <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
         ir    <= ir_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir;
      retire  = 1'b0;
      case (state)
         IDLE: if (start) state_n = FETCH;
         FETCH: begin
            if (imem_ack) begin
               ir_n    = imem_rdata;
               pc_n    = pc + PC_W'(1);
               state_n = DECODE;
            end else if (to_expired) begin
               state_n = ERR;
            end
         end
         DECODE: begin
            if (op == OP_HALT) begin
               state_n = HALT;
               retire  = 1'b1;
            end else if (op == OP_J) begin
               pc_n    = ir[PC_W-1:0];
               state_n = FETCH;
               retire  = 1'b1;
            end else if (!is_legal(op)) begin
               state_n = ERR;
            end else begin
               state_n = EXEC;
            end
         end
         EXEC: begin
            if (is_branch(op)) begin
               if (alu_zero) pc_n = pc + br_off;
               state_n = FETCH;
               retire  = 1'b1;
            end else if ((op == OP_LW) || (op == OP_SW)) begin
               state_n = MEM;
            end else begin
               state_n = WB;
            end
         end
         MEM: begin
            if (dmem_ack) begin
               if (op == OP_SW) begin
                  state_n = FETCH;
                  retire  = 1'b1;
               end else begin
                  state_n = WB;
               end
            end else if (to_expired) begin
               state_n = ERR;
            end
         end
         WB: begin
            state_n = FETCH;
            retire  = 1'b1;
         end
         HALT: if (start) state_n = FETCH;
         ERR:  state_n = ERR;
         default: state_n = IDLE;
      endcase
   end

   assign imem_req    = (state == FETCH);
   assign imem_addr   = pc;
   assign dmem_req    = (state == MEM);
   assign dmem_we     = (state == MEM) && (op == OP_SW);
   assign alu_op_code = op;
   assign alu_func    = ir[5:0];
   assign alu_src_imm = (state == EXEC) && is_imm(op);
   assign reg_we      = (state == WB);
   assign reg_dst_rd  = (state == WB) && (op == OP_RTYPE);
   assign wb_sel_mem  = (state == WB) && (op == OP_LW);
   assign busy        = !((state == IDLE) || (state == HALT) || (state == ERR));
   assign halted      = (state == HALT);
   assign err         = (state == ERR);

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         instr_retired <= '0;
      else if (retire) instr_retired <= instr_retired + 32'd1;
   end
`else
   // Retire strobe only feeds the optional counter.
   logic unused_retire;
   assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;
   import mips_pkg::*;

   localparam logic [31:0] W_HALT = 32'hFC000000;
   localparam logic [31:0] W_ADD  = 32'h00221820; // add r3,r1,r2 (func 32)
   localparam logic [31:0] W_LW   = 32'h8C220004;
   localparam logic [31:0] W_SW   = 32'hAC220008;
   localparam logic [31:0] W_BEQ  = 32'hA422FFFE; // op 41, imm -2
   localparam logic [31:0] W_ADDI = 32'h20220001;

   logic        clk = 1'b0;
   logic        rst, start, alu_zero, ack_en;
   logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
   logic [31:0] imem_rdata, ir;
   logic [9:0]  imem_addr, pc;
   logic [5:0]  alu_op_code, alu_func;
   logic        alu_src_imm, reg_we, reg_dst_rd, wb_sel_mem, busy, halted, err;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instr_retired;
`endif

   logic [31:0] imem [0:1023];
   int dmem_delay;
   int dcnt;
   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   assign imem_ack   = imem_req & ack_en;
   assign imem_rdata = imem[imem_addr];
   assign dmem_ack   = dmem_req && (dcnt >= dmem_delay);
   always @(posedge clk) begin
      if (!dmem_req || dmem_ack) dcnt <= 0;
      else                       dcnt <= dcnt + 1;
   end

   mips_multicycle_ctrl #(.PC_W(10), .RESET_PC(0), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
      .alu_op_code(alu_op_code), .alu_func(alu_func), .alu_src_imm(alu_src_imm),
      .ir(ir), .pc(pc), .reg_we(reg_we), .reg_dst_rd(reg_dst_rd), .wb_sel_mem(wb_sel_mem),
      .busy(busy), .halted(halted), .err(err)
`ifdef CTRL_PERF_CNT_EN
      , .instr_retired(instr_retired)
`endif
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; alu_zero = 1'b0; ack_en = 1'b1; dmem_delay = 0;
      for (int i = 0; i < 1024; i++) imem[i] = W_HALT;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Leaves the bench at the negedge of cycle 1 (first FETCH cycle).
   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic run_to_stop(output int n, output int we_seen);
      n = 0; we_seen = 0;
      while (!halted && !err && n < 100) begin
         if (reg_we) we_seen++;
         tick(); n++;
      end
      total_cnt++;
      if (n >= 100) $display("FAIL run_bound: no halt after %0d cycles", n); else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; alu_zero = 1'b0; ack_en = 1'b1; dmem_delay = 0;
      tick(); tick();
      total_cnt++; if (dut.state !== IDLE) $display("FAIL rst_state: got %0d want %0d", dut.state, IDLE); else pass_cnt++;
      total_cnt++; if (pc !== 10'd0 || ir !== 32'd0) $display("FAIL rst_pc_ir: got pc=%0d ir=%h want 0/0", pc, ir); else pass_cnt++;
      total_cnt++; if ({imem_req, dmem_req, dmem_we, reg_we, busy, halted, err} !== 7'b0)
         $display("FAIL rst_outs: got %b want 0000000", {imem_req, dmem_req, dmem_we, reg_we, busy, halted, err}); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_rtype();
      int n, we;
      do_reset(); imem[0] = W_ADD;
      pulse_start();
      total_cnt++; if (dut.state !== FETCH || imem_req !== 1'b1) $display("FAIL rt_c1: got st=%0d req=%b want FETCH/1", dut.state, imem_req); else pass_cnt++;
      tick();
      total_cnt++; if (dut.state !== DECODE || ir !== W_ADD || pc !== 10'd1) $display("FAIL rt_c2: got st=%0d ir=%h pc=%0d want DECODE/%h/1", dut.state, ir, pc, W_ADD); else pass_cnt++;
      tick();
      total_cnt++; if (dut.state !== EXEC || alu_op_code !== 6'd0 || alu_func !== 6'd32 || alu_src_imm !== 1'b0 || reg_we !== 1'b0)
         $display("FAIL rt_c3: got st=%0d op=%0d fn=%0d imm=%b we=%b want EXEC/0/32/0/0", dut.state, alu_op_code, alu_func, alu_src_imm, reg_we); else pass_cnt++;
      start = 1'b1; tick(); start = 1'b0; // start while busy must be ignored
      total_cnt++; if (dut.state !== WB || reg_we !== 1'b1 || reg_dst_rd !== 1'b1 || wb_sel_mem !== 1'b0 || pc !== 10'd1)
         $display("FAIL rt_c4: got st=%0d we=%b rd=%b mem=%b pc=%0d want WB/1/1/0/1", dut.state, reg_we, reg_dst_rd, wb_sel_mem, pc); else pass_cnt++;
      tick();
      total_cnt++; if (reg_we !== 1'b0 || dut.state !== FETCH) $display("FAIL rt_c5: got we=%b st=%0d want 0/FETCH", reg_we, dut.state); else pass_cnt++;
      run_to_stop(n, we);
      total_cnt++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 10'd2) $display("FAIL rt_halt: got h=%b b=%b pc=%0d want 1/0/2", halted, busy, pc); else pass_cnt++;
   endtask

   task automatic test_lw();
      int n, reqc, weerr;
      do_reset(); imem[0] = W_LW; dmem_delay = 3;
      pulse_start();
      n = 1; reqc = 0; weerr = 0;
      while (dut.state !== WB && n < 40) begin
         if (dmem_req) begin reqc++; if (dmem_we) weerr++; end
         tick(); n++;
      end
      total_cnt++; if (n !== 8) $display("FAIL lw_latency: got %0d want 8", n); else pass_cnt++;
      total_cnt++; if (reqc !== 4 || weerr !== 0) $display("FAIL lw_req: got req_cycles=%0d we_cycles=%0d want 4/0", reqc, weerr); else pass_cnt++;
      total_cnt++; if (reg_we !== 1'b1 || wb_sel_mem !== 1'b1 || reg_dst_rd !== 1'b0) $display("FAIL lw_wb: got we=%b mem=%b rd=%b want 1/1/0", reg_we, wb_sel_mem, reg_dst_rd); else pass_cnt++;
   endtask

   task automatic test_sw();
      int n, we;
      do_reset(); imem[0] = W_SW;
      pulse_start(); tick(); tick(); tick();
      total_cnt++; if (dut.state !== MEM || dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL sw_mem: got st=%0d req=%b we=%b want MEM/1/1", dut.state, dmem_req, dmem_we); else pass_cnt++;
      tick();
      total_cnt++; if (dut.state !== FETCH || pc !== 10'd1 || reg_we !== 1'b0) $display("FAIL sw_done: got st=%0d pc=%0d we=%b want FETCH/1/0", dut.state, pc, reg_we); else pass_cnt++;
      run_to_stop(n, we);
      total_cnt++; if (we !== 0) $display("FAIL sw_no_wb: got %0d reg_we cycles want 0", we); else pass_cnt++;
   endtask

   task automatic test_branch(input logic z, input logic [9:0] exp_pc);
      int n, we;
      do_reset(); imem[0] = 32'h08000004; imem[4] = W_BEQ; alu_zero = z;
      pulse_start(); tick(); tick();
      total_cnt++; if (dut.state !== FETCH || pc !== 10'd4) $display("FAIL br_jump z=%b: got st=%0d pc=%0d want FETCH/4", z, dut.state, pc); else pass_cnt++;
      tick(); tick();
      total_cnt++; if (dut.state !== EXEC || pc !== 10'd5 || alu_op_code !== 6'd41) $display("FAIL br_exec z=%b: got st=%0d pc=%0d op=%0d want EXEC/5/41", z, dut.state, pc, alu_op_code); else pass_cnt++;
      tick();
      total_cnt++; if (dut.state !== FETCH || pc !== exp_pc || reg_we !== 1'b0) $display("FAIL br_target z=%b: got st=%0d pc=%0d we=%b want FETCH/%0d/0", z, dut.state, pc, reg_we, exp_pc); else pass_cnt++;
      run_to_stop(n, we);
      total_cnt++; if (we !== 0 || halted !== 1'b1) $display("FAIL br_no_wb z=%b: got we=%0d h=%b want 0/1", z, we, halted); else pass_cnt++;
   endtask

   task automatic test_jump_wrap();
      do_reset(); imem[0] = 32'h080003FF; imem[1023] = W_ADDI;
      pulse_start(); tick(); tick();
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) $display("FAIL jw_fetch: got req=%b addr=%h want 1/3ff", imem_req, imem_addr); else pass_cnt++;
      tick();
      total_cnt++; if (pc !== 10'd0 || ir !== W_ADDI) $display("FAIL jw_wrap: got pc=%0d ir=%h want 0/%h", pc, ir, W_ADDI); else pass_cnt++;
      tick();
      total_cnt++; if (alu_src_imm !== 1'b1 || alu_op_code !== 6'd8) $display("FAIL jw_imm: got imm=%b op=%0d want 1/8", alu_src_imm, alu_op_code); else pass_cnt++;
      tick();
      total_cnt++; if (reg_we !== 1'b1 || reg_dst_rd !== 1'b0) $display("FAIL jw_wb: got we=%b rd=%b want 1/0", reg_we, reg_dst_rd); else pass_cnt++;
   endtask

   task automatic test_timeout();
      do_reset(); ack_en = 1'b0;
      pulse_start();
      for (int i = 0; i < 14; i++) tick();
      total_cnt++; if (dut.state !== FETCH || err !== 1'b0 || imem_req !== 1'b1) $display("FAIL to_c15: got st=%0d err=%b req=%b want FETCH/0/1", dut.state, err, imem_req); else pass_cnt++;
      tick();
      total_cnt++; if (err !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0) $display("FAIL to_c16: got err=%b busy=%b req=%b want 1/0/0", err, busy, imem_req); else pass_cnt++;
      ack_en = 1'b1;
      pulse_start(); tick();
      total_cnt++; if (dut.state !== ERR || err !== 1'b1 || imem_req !== 1'b0) $display("FAIL to_sticky: got st=%0d err=%b req=%b want ERR/1/0", dut.state, err, imem_req); else pass_cnt++;
   endtask

   task automatic test_illegal();
      do_reset(); imem[0] = 32'h04000000; // opcode 1
      pulse_start(); tick(); tick();
      total_cnt++; if (err !== 1'b1 || busy !== 1'b0 || reg_we !== 1'b0) $display("FAIL ill_err: got err=%b busy=%b we=%b want 1/0/0", err, busy, reg_we); else pass_cnt++;
   endtask

   task automatic test_halt_resume();
      int n, we;
      do_reset(); imem[1] = W_ADD;
      pulse_start(); tick(); tick();
      total_cnt++; if (halted !== 1'b1 || busy !== 1'b0 || pc !== 10'd1) $display("FAIL hr_halt: got h=%b b=%b pc=%0d want 1/0/1", halted, busy, pc); else pass_cnt++;
      pulse_start();
      total_cnt++; if (dut.state !== FETCH || imem_addr !== 10'd1 || halted !== 1'b0) $display("FAIL hr_resume: got st=%0d addr=%0d h=%b want FETCH/1/0", dut.state, imem_addr, halted); else pass_cnt++;
      run_to_stop(n, we);
      total_cnt++; if (pc !== 10'd3 || we !== 1 || halted !== 1'b1) $display("FAIL hr_end: got pc=%0d we=%0d h=%b want 3/1/1", pc, we, halted); else pass_cnt++;
   endtask

   task automatic test_rst_mid_mem();
      do_reset(); imem[0] = W_LW; dmem_delay = 20;
      pulse_start(); tick(); tick(); tick(); tick();
      total_cnt++; if (dmem_req !== 1'b1 || pc !== 10'd1) $display("FAIL rm_mem: got req=%b pc=%0d want 1/1", dmem_req, pc); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (dmem_req !== 1'b0 || dut.state !== IDLE || pc !== 10'd0 || reg_we !== 1'b0 || busy !== 1'b0)
         $display("FAIL rm_async: got req=%b st=%0d pc=%0d we=%b busy=%b want 0/IDLE/0/0/0", dmem_req, dut.state, pc, reg_we, busy); else pass_cnt++;
      tick(); rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_sw();
      test_branch(1'b1, 10'd3);
      test_branch(1'b0, 10'd5);
      test_jump_wrap();
      test_timeout();
      test_illegal();
      test_halt_resume();
      test_rst_mid_mem();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
